fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_branch_lut.sv | 22 ++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// default widths and the branch lookup-table contents.
package fetch_unit_pkg;

    localparam int unsigned PC_W_DEFAULT = 10;
    localparam int unsigned LUT_IDX_W    = 5;
    localparam int unsigned LUT_DEPTH    = 32;
    localparam int unsigned LUT_STRIDE   = 25;
    localparam int unsigned CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    // Absolute-branch target stored at a given table slot.
    function automatic int unsigned lut_value(input int unsigned idx);
        return idx * LUT_STRIDE;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational 32-entry absolute-branch target table, indexed by the
// low five bits of the branch operand.
module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);

    logic [PC_W-1:0] table_q [LUT_DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
            table_q[i] = PC_W'(lut_value(i));
        end
    end

    assign target = table_q[idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE/RUN/HALT control, branch resolution and
// RUN-cycle counting. Define FETCH_TARGET_LUT_EN to source absolute branch
// targets from the branch_lut table instead of PCTarg.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     PC_W       = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchAbs,
    input  logic             BranchRel,
    input  logic             Taken,
    input  logic             Ack,
    input  logic [PC_W-1:0]  PCTarg,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    fetch_state_t     state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PC_W-1:0]  abs_target;

`ifdef FETCH_TARGET_LUT_EN
    branch_lut #(
        .PC_W (PC_W)
    ) u_branch_lut (
        .idx    (PCTarg[LUT_IDX_W-1:0]),
        .target (abs_target)
    );
`else
    assign abs_target = PCTarg;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        cnt_nxt   = CycleCnt;
        case (state)
            IDLE: begin
                pc_nxt = START_ADDR;
                if (Start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (CycleCnt != '1) begin
                    cnt_nxt = CycleCnt + CNT_W'(1);
                end
                // STOP outranks any branch decoded in the same cycle
                if (Ack) begin
                    state_nxt = HALT;
                end else if (BranchAbs && Taken) begin
                    pc_nxt = abs_target;
                end else if (BranchRel && Taken) begin
                    pc_nxt = ProgCtr + PCTarg;
                end else begin
                    pc_nxt = ProgCtr + PC_W'(1);
                end
            end
            HALT: begin
                if (!Start) begin
                    state_nxt = IDLE;
                    pc_nxt    = START_ADDR;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            ProgCtr  <= START_ADDR;
            CycleCnt <= '0;
            Running  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ProgCtr  <= pc_nxt;
            CycleCnt <= cnt_nxt;
            Running  <= (state_nxt == RUN);
            Done     <= (state_nxt == HALT);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: expected PC/status pushed per
// step, popped and asserted one cycle later.
module tb_fetch_unit;

    localparam int unsigned PC_W = 10;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic            BranchAbs;
    logic            BranchRel;
    logic            Taken;
    logic            Ack;
    logic [PC_W-1:0] PCTarg;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
    logic            Done;
    logic [15:0]     CycleCnt;

    typedef struct {
        string           tag;
        logic [PC_W-1:0] pc;
        logic            run;
        logic            done;
        logic [15:0]     cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef FETCH_TARGET_LUT_EN
    localparam logic [PC_W-1:0] ABS_PC = 10'd200;
`else
    localparam logic [PC_W-1:0] ABS_PC = 10'd40;
`endif

    fetch_unit #(
        .PC_W       (PC_W),
        .START_ADDR (10'd0)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .BranchAbs (BranchAbs),
        .BranchRel (BranchRel),
        .Taken     (Taken),
        .Ack       (Ack),
        .PCTarg    (PCTarg),
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done),
        .CycleCnt  (CycleCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check_now(input string tag, input logic [PC_W-1:0] pc,
                             input logic run, input logic done, input logic [15:0] cnt);
        n_checks++;
        assert (ProgCtr === pc) else begin
            n_fail++;
            $error("FAIL %s ProgCtr got %h want %h", tag, ProgCtr, pc);
        end
        n_checks++;
        assert (Running === run) else begin
            n_fail++;
            $error("FAIL %s Running got %b want %b", tag, Running, run);
        end
        n_checks++;
        assert (Done === done) else begin
            n_fail++;
            $error("FAIL %s Done got %b want %b", tag, Done, done);
        end
        n_checks++;
        assert (CycleCnt === cnt) else begin
            n_fail++;
            $error("FAIL %s CycleCnt got %h want %h", tag, CycleCnt, cnt);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge result, compare after the edge.
    task automatic step(input string tag, input logic st, input logic ba, input logic br,
                        input logic tk, input logic ak, input logic [PC_W-1:0] tg,
                        input logic [PC_W-1:0] pc, input logic run, input logic done,
                        input logic [15:0] cnt);
        exp_t e;
        Start = st; BranchAbs = ba; BranchRel = br; Taken = tk; Ack = ak; PCTarg = tg;
        e.tag = tag; e.pc = pc; e.run = run; e.done = done; e.cnt = cnt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_now(e.tag, e.pc, e.run, e.done, e.cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Start = 1'b1;
        BranchAbs = 1'b0; BranchRel = 1'b0; Taken = 1'b0; Ack = 1'b0; PCTarg = '0;
        #12;
        check_now("reset", 10'd0, 1'b0, 1'b0, 16'd0);
        Reset = 1'b1;

        step("start_e1", 1, 0, 0, 0, 0, 10'd0, 10'd0, 1, 0, 16'd0);
        step("seq_e2",   1, 0, 0, 0, 0, 10'd0, 10'd1, 1, 0, 16'd1);
        step("seq_e3",   1, 0, 0, 0, 0, 10'd0, 10'd2, 1, 0, 16'd2);
        step("seq_e4",   1, 0, 0, 0, 0, 10'd0, 10'd3, 1, 0, 16'd3);
        step("rel_fwd",  1, 0, 1, 1, 0, 10'd2, 10'd5, 1, 0, 16'd4);
        step("rel_back", 1, 0, 1, 1, 0, 10'h3FE, 10'd3, 1, 0, 16'd5);
        step("rel_fwd2", 1, 0, 1, 1, 0, 10'd2, 10'd5, 1, 0, 16'd6);
        step("rel_nt",   1, 0, 1, 0, 0, 10'h3FE, 10'd6, 1, 0, 16'd7);
        step("seq_7",    1, 0, 0, 0, 0, 10'd0, 10'd7, 1, 0, 16'd8);
        step("abs_rel",  1, 1, 1, 1, 0, 10'd40, ABS_PC, 1, 0, 16'd9);
        step("rel_3ff",  1, 0, 1, 1, 0, 10'h3FF - ABS_PC, 10'h3FF, 1, 0, 16'd10);
        step("wrap",     1, 0, 0, 0, 0, 10'd0, 10'd0, 1, 0, 16'd11);
        step("rel_12",   1, 0, 1, 1, 0, 10'd12, 10'd12, 1, 0, 16'd12);
        step("ack_abs",  1, 1, 0, 1, 1, 10'd40, 10'd12, 0, 1, 16'd13);
        step("halt_h1",  1, 1, 1, 1, 0, 10'd40, 10'd12, 0, 1, 16'd13);
        step("halt_h2",  1, 0, 0, 0, 1, 10'd0, 10'd12, 0, 1, 16'd13);
        step("to_idle",  0, 0, 0, 0, 0, 10'd0, 10'd0, 0, 0, 16'd13);
        step("idle_ign", 0, 1, 1, 1, 1, 10'd40, 10'd0, 0, 0, 16'd13);
        step("restart",  1, 0, 0, 0, 0, 10'd0, 10'd0, 1, 0, 16'd0);
        step("rel_37",   1, 0, 1, 1, 0, 10'd37, 10'd37, 1, 0, 16'd1);

        #2;
        Reset = 1'b0;
        #1;
        check_now("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
        @(posedge Clk);
        #1;
        check_now("rst_hold", 10'd0, 1'b0, 1'b0, 16'd0);

        Start = 1'b1; BranchAbs = 1'b0; BranchRel = 1'b0; Taken = 1'b0; Ack = 1'b0;
        Reset = 1'b1;
        repeat (65540) @(posedge Clk);
        #1;
        check_now("saturate", 10'd3, 1'b1, 1'b0, 16'hFFFF);
        step("sat_hold", 1, 0, 0, 0, 0, 10'd0, 10'd4, 1, 0, 16'hFFFF);
        step("sat_stop", 1, 0, 0, 0, 1, 10'd0, 10'd4, 0, 1, 16'hFFFF);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain size got %0d want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
